// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS mnemonic codes, opcode/funct constants and encoder FSM states
// Contents:
//   mnem_e     symbolic instruction codes 0..27; codes 28..31 are illegal
//   OP_* / F_* standard MIPS primary opcodes and SPECIAL funct values
//   state_e    encoder control states
//   funct_of / opcode_of  mnemonic-to-field lookups
package mips_isa_pkg;

  typedef enum logic [4:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_SLTU, M_ADDU, M_SUBU, M_SLL, M_NOR,
    M_SRL, M_SLLV, M_JR, M_JALR, M_XOR, M_SRA, M_SRAV, M_ADDI, M_ORI, M_LW,
    M_SW, M_BEQ, M_LUI, M_SLTI, M_ANDI, M_J, M_JAL, M_BNE
  } mnem_e;

  localparam logic [4:0] MNEM_LAST = 5'd27;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08,
                         OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_ORI = 6'h0d,
                         OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                         F_SLLV = 6'h04, F_SRAV = 6'h07, F_JR = 6'h08,
                         F_JALR = 6'h09, F_ADD = 6'h20, F_ADDU = 6'h21,
                         F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2a, F_SLTU = 6'h2b;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  function automatic logic [5:0] funct_of(input logic [4:0] m);
    case (m)
      M_ADD:  return F_ADD;
      M_ADDU: return F_ADDU;
      M_SUB:  return F_SUB;
      M_SUBU: return F_SUBU;
      M_AND:  return F_AND;
      M_OR:   return F_OR;
      M_XOR:  return F_XOR;
      M_NOR:  return F_NOR;
      M_SLT:  return F_SLT;
      M_SLTU: return F_SLTU;
      M_SLL:  return F_SLL;
      M_SRL:  return F_SRL;
      M_SRA:  return F_SRA;
      M_SLLV: return F_SLLV;
      M_SRAV: return F_SRAV;
      M_JR:   return F_JR;
      M_JALR: return F_JALR;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] opcode_of(input logic [4:0] m);
    case (m)
      M_ADDI: return OP_ADDI;
      M_ORI:  return OP_ORI;
      M_ANDI: return OP_ANDI;
      M_SLTI: return OP_SLTI;
      M_LW:   return OP_LW;
      M_SW:   return OP_SW;
      M_BEQ:  return OP_BEQ;
      M_BNE:  return OP_BNE;
      M_LUI:  return OP_LUI;
      M_J:    return OP_J;
      M_JAL:  return OP_JAL;
      default: return OP_SPECIAL;
    endcase
  endfunction

endpackage

// File: rtl/mips_instr_encoder_if.sv
// rtl/mips_instr_encoder_if.sv - request/word handshake bundle for the instruction encoder
// Signals:
//   in_valid/in_ready + in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm : symbolic request
//   out_valid/out_ready + out_instr, out_addr                          : encoded word stream
// Modports: master = request producer / word consumer, slave = encoder
interface mips_instr_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [25:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/enc_fifo2.sv
// rtl/enc_fifo2.sv - two-entry FIFO holding encoded words; occupancy doubles as per-entry valid
// Ports:
//   clk, rst           clock, synchronous active-high reset (empties the FIFO, clears storage)
//   push, push_data    write request and word (ignored when full)
//   pop, pop_data      read request (ignored when empty) and head word
//   count, full, empty occupancy and flags
module enc_fifo2 #(parameter int W = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Separate read/write pointers keep order intact when push and pop coincide at count 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) rd_ptr <= !rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - streaming symbolic-to-machine-word MIPS encoder with program quota
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus (slave)  request handshake in, encoded word + word address out
//   err_illegal  sticky flag: an illegal mnemonic (28..31) was accepted
//   err_count    saturating count of accepted illegal requests
//   busy         high while in RUN or DRAIN
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256,
  parameter int ERR_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_instr_encoder_if.slave  bus,
  output logic                 err_illegal,
  output logic [ERR_W-1:0]     err_count,
  output logic                 busy
);
  localparam int PC_W = $clog2(MAX_WORDS + 1);

  function automatic logic [31:0] encode(input logic [4:0] m, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [25:0] imm);
    logic [31:0] w;
    w = 32'h0;
    case (m)
      M_SLL, M_SRL, M_SRA:
        w = {OP_SPECIAL, 5'h0, rt, rd, sh, funct_of(m)};
      M_JR:   w = {OP_SPECIAL, rs, 15'h0, F_JR};
      M_JALR: w = {OP_SPECIAL, rs, 5'h0, rd, 5'h0, F_JALR};
      M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
      M_SLLV, M_SRAV:
        w = {OP_SPECIAL, rs, rt, rd, 5'h0, funct_of(m)};
      M_LUI:  w = {OP_LUI, 5'h0, rt, imm[15:0]};
      M_ADDI, M_ORI, M_ANDI, M_SLTI, M_LW, M_SW, M_BEQ, M_BNE:
        w = {opcode_of(m), rs, rt, imm[15:0]};
      M_J, M_JAL: w = {opcode_of(m), imm};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  state_e            state, state_nxt;
  logic              legal, accept, push, pop;
  logic [31:0]       enc_word, fifo_dout;
  logic [1:0]        fifo_count;
  logic              fifo_full, fifo_empty;
  logic [PC_W-1:0]   push_cnt;
  logic [ADDR_W-1:0] pop_cnt;

  assign legal    = (bus.in_mnem <= MNEM_LAST);
  // Depends only on registered state (and rst), never on out_ready.
  assign bus.in_ready  = !rst && (state == S_RUN) && !fifo_full;
  assign accept        = bus.in_valid && bus.in_ready;
  assign push          = accept && legal;
  assign bus.out_valid = (state != S_DONE) && !fifo_empty;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_instr = fifo_dout;
  assign bus.out_addr  = pop_cnt;
  assign busy          = !rst && (state != S_DONE);

  assign enc_word = encode(bus.in_mnem, bus.in_rs, bus.in_rt, bus.in_rd,
                           bus.in_shamt, bus.in_imm);

  enc_fifo2 #(.W(32)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (enc_word),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (push && (push_cnt == PC_W'(MAX_WORDS - 1))) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_count == 2'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_cnt    <= '0;
      pop_cnt     <= '0;
      err_illegal <= 1'b0;
      err_count   <= '0;
    end else begin
      if (push) push_cnt <= push_cnt + PC_W'(1);
      if (pop)  pop_cnt  <= pop_cnt + ADDR_W'(1);
      if (accept && !legal) begin
        err_illegal <= 1'b1;
        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + ERR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - directed table-driven bench for mips_instr_encoder
// Three instances: u0 default, u1 with a 4-word quota, u2 with 2-bit addresses.
// Stimulus is shared; 'sel' chooses which instance sees in_valid and is observed.
module tb_mips_instr_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        in_valid, out_ready;
  logic [4:0]  in_mnem, in_rs, in_rt, in_rd, in_shamt;
  logic [25:0] in_imm;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  mips_instr_encoder_if #(.ADDR_W(8)) bus0 ();
  mips_instr_encoder_if #(.ADDR_W(8)) bus1 ();
  mips_instr_encoder_if #(.ADDR_W(2)) bus2 ();
  logic       err0, err1, err2, busy0, busy1, busy2;
  logic [7:0] cnt0, cnt1, cnt2;

  assign bus0.in_valid = in_valid && (sel == 2'd0);
  assign bus1.in_valid = in_valid && (sel == 2'd1);
  assign bus2.in_valid = in_valid && (sel == 2'd2);
  assign bus0.in_mnem = in_mnem;  assign bus1.in_mnem = in_mnem;  assign bus2.in_mnem = in_mnem;
  assign bus0.in_rs = in_rs;      assign bus1.in_rs = in_rs;      assign bus2.in_rs = in_rs;
  assign bus0.in_rt = in_rt;      assign bus1.in_rt = in_rt;      assign bus2.in_rt = in_rt;
  assign bus0.in_rd = in_rd;      assign bus1.in_rd = in_rd;      assign bus2.in_rd = in_rd;
  assign bus0.in_shamt = in_shamt; assign bus1.in_shamt = in_shamt; assign bus2.in_shamt = in_shamt;
  assign bus0.in_imm = in_imm;    assign bus1.in_imm = in_imm;    assign bus2.in_imm = in_imm;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready; assign bus2.out_ready = out_ready;

  mips_instr_encoder #(.ADDR_W(8), .MAX_WORDS(256), .ERR_W(8)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .err_illegal(err0), .err_count(cnt0), .busy(busy0));
  mips_instr_encoder #(.ADDR_W(8), .MAX_WORDS(4), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .err_illegal(err1), .err_count(cnt1), .busy(busy1));
  mips_instr_encoder #(.ADDR_W(2), .MAX_WORDS(256), .ERR_W(8)) u2 (
    .clk(clk), .rst(rst), .bus(bus2), .err_illegal(err2), .err_count(cnt2), .busy(busy2));

  logic        c_in_ready, c_out_valid, c_err, c_busy;
  logic [31:0] c_instr;
  logic [7:0]  c_addr, c_cnt;

  always_comb begin
    c_in_ready = bus0.in_ready; c_out_valid = bus0.out_valid; c_instr = bus0.out_instr;
    c_addr = bus0.out_addr; c_err = err0; c_cnt = cnt0; c_busy = busy0;
    if (sel == 2'd1) begin
      c_in_ready = bus1.in_ready; c_out_valid = bus1.out_valid; c_instr = bus1.out_instr;
      c_addr = bus1.out_addr; c_err = err1; c_cnt = cnt1; c_busy = busy1;
    end else if (sel == 2'd2) begin
      c_in_ready = bus2.in_ready; c_out_valid = bus2.out_valid; c_instr = bus2.out_instr;
      c_addr = 8'(bus2.out_addr); c_err = err2; c_cnt = cnt2; c_busy = busy2;
    end
  end

  typedef struct {
    logic [4:0]  mnem, rs, rt, rd, sh;
    logic [25:0] imm;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [0:15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic [4:0] m, rs, rt, rd, sh, input logic [25:0] imm);
    in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // Offers one request and returns #1 after the edge at which it was accepted.
  task automatic send(input logic [4:0] m, rs, rt, rd, sh, input logic [25:0] imm);
    bit done;
    done = 1'b0;
    set_req(m, rs, rt, rd, sh, imm);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (c_in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_accept required=accept mnem=%0d", m);
    end
  endtask

  task automatic send_vec(input int i);
    send(vecs[i].mnem, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{5'd17, 5'd0,  5'd8,  5'd0,  5'd0,  26'd5,          32'h20080005}; // addi
    vecs[1]  = '{5'd0,  5'd1,  5'd2,  5'd3,  5'd0,  26'd0,          32'h00221820}; // add
    vecs[2]  = '{5'd8,  5'd7,  5'd1,  5'd2,  5'd4,  26'd0,          32'h00011100}; // sll
    vecs[3]  = '{5'd19, 5'd29, 5'd9,  5'd0,  5'd0,  26'd8,          32'h8FA90008}; // lw
    vecs[4]  = '{5'd25, 5'd0,  5'd0,  5'd0,  5'd0,  26'h0100000,    32'h08100000}; // j
    vecs[5]  = '{5'd12, 5'd31, 5'd5,  5'd6,  5'd3,  26'h0,          32'h03E00008}; // jr
    vecs[6]  = '{5'd13, 5'd4,  5'd7,  5'd31, 5'd2,  26'h0,          32'h0080F809}; // jalr
    vecs[7]  = '{5'd22, 5'd3,  5'd2,  5'd1,  5'd1,  26'h1234,       32'h3C021234}; // lui
    vecs[8]  = '{5'd21, 5'd1,  5'd2,  5'd0,  5'd0,  26'h3FFFFFF,    32'h1022FFFF}; // beq
    vecs[9]  = '{5'd15, 5'd9,  5'd3,  5'd4,  5'd31, 26'h0,          32'h000327C3}; // sra
    vecs[10] = '{5'd11, 5'd5,  5'd6,  5'd7,  5'd9,  26'h0,          32'h00A63804}; // sllv
    vecs[11] = '{5'd9,  5'd1,  5'd2,  5'd3,  5'd1,  26'h0,          32'h00221827}; // nor
    vecs[12] = '{5'd26, 5'd0,  5'd0,  5'd0,  5'd0,  26'h3FFFFFF,    32'h0FFFFFFF}; // jal
    vecs[13] = '{5'd20, 5'd29, 5'd31, 5'd0,  5'd0,  26'hFFFC,       32'hAFBFFFFC}; // sw
    vecs[14] = '{5'd27, 5'd8,  5'd0,  5'd0,  5'd0,  26'd3,          32'h15000003}; // bne
    vecs[15] = '{5'd5,  5'd2,  5'd3,  5'd4,  5'd0,  26'd0,          32'h0043202B}; // sltu

    sel = 2'd0; out_ready = 1'b1; in_valid = 1'b0;
    in_mnem = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", c_in_ready, 0);
    chk("rst_out_valid", c_out_valid, 0);
    chk("rst_busy", c_busy, 0);
    chk("rst_out_instr", c_instr, 0);
    chk("rst_out_addr", c_addr, 0);
    chk("rst_err", {c_err, c_cnt}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", c_in_ready, 1);
    chk("post_rst_busy", c_busy, 1);
    @(posedge clk); #1;

    // Encoding table, streamed with out_ready high.
    for (int i = 0; i < 16; i++) begin
      send_vec(i);
      chk($sformatf("vec%0d_valid", i), c_out_valid, 1);
      chk($sformatf("vec%0d_instr", i), c_instr, vecs[i].exp);
      chk($sformatf("vec%0d_addr", i), c_addr, i);
    end
    @(posedge clk); #1;
    chk("stream_empty", c_out_valid, 0);

    // Backpressure: two accepted, third held off, then ordered drain.
    do_reset();
    out_ready = 1'b0;
    set_req(vecs[0].mnem, vecs[0].rs, vecs[0].rt, vecs[0].rd, vecs[0].sh, vecs[0].imm);
    @(negedge clk); chk("bp_ready_a", c_in_ready, 1);
    @(posedge clk); #1;
    set_req(vecs[1].mnem, vecs[1].rs, vecs[1].rt, vecs[1].rd, vecs[1].sh, vecs[1].imm);
    @(negedge clk); chk("bp_ready_b", c_in_ready, 1);
    @(posedge clk); #1;
    set_req(vecs[2].mnem, vecs[2].rs, vecs[2].rt, vecs[2].rd, vecs[2].sh, vecs[2].imm);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_full_ready", c_in_ready, 0);
      chk("bp_hold_instr", c_instr, vecs[0].exp);
      chk("bp_hold_addr", c_addr, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w0_instr", c_instr, vecs[0].exp); chk("bp_w0_addr", c_addr, 0);
    chk("bp_w0_ready", c_in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_w1_instr", c_instr, vecs[1].exp); chk("bp_w1_addr", c_addr, 1);
    chk("bp_w1_ready", c_in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_w2_valid", c_out_valid, 1);
    chk("bp_w2_instr", c_instr, vecs[2].exp); chk("bp_w2_addr", c_addr, 2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_empty", c_out_valid, 0);
    @(posedge clk); #1;

    // Illegal mnemonic: handshake completes, nothing pushed.
    do_reset();
    send(5'd30, 5'd1, 5'd2, 5'd3, 5'd4, 26'd5);
    chk("ill_no_valid", c_out_valid, 0);
    chk("ill_sticky", c_err, 1);
    chk("ill_count", c_cnt, 1);
    send_vec(0);
    chk("ill_next_valid", c_out_valid, 1);
    chk("ill_next_instr", c_instr, vecs[0].exp);
    chk("ill_next_addr", c_addr, 0);

    // Quota of 4 on u1: DRAIN then DONE.
    sel = 2'd1;
    do_reset();
    for (int i = 0; i < 4; i++) send_vec(i);
    chk("q_drain_ready", c_in_ready, 0);
    chk("q_drain_busy", c_busy, 1);
    chk("q_drain_instr", c_instr, vecs[3].exp);
    chk("q_drain_addr", c_addr, 3);
    set_req(vecs[4].mnem, vecs[4].rs, vecs[4].rt, vecs[4].rd, vecs[4].sh, vecs[4].imm);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("q_done_busy", c_busy, 0);
    chk("q_done_valid", c_out_valid, 0);
    chk("q_done_ready", c_in_ready, 0);
    chk("q_done_addr", c_addr, 4);
    @(posedge clk); #1;

    // Reset while in DRAIN with a full buffer.
    do_reset();
    for (int i = 0; i < 3; i++) send_vec(i);
    out_ready = 1'b0;
    send_vec(3);
    chk("qr_drain_ready", c_in_ready, 0);
    chk("qr_drain_valid", c_out_valid, 1);
    chk("qr_drain_instr", c_instr, vecs[2].exp);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("qr_rst_valid", c_out_valid, 0);
    chk("qr_rst_instr", c_instr, 0);
    chk("qr_rst_addr", c_addr, 0);
    chk("qr_rst_ready_busy", {c_in_ready, c_busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("qr_after_ready_busy", {c_in_ready, c_busy}, 2'b11);
    chk("qr_after_valid", c_out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // 2-bit address wrap and error-counter saturation on u2.
    sel = 2'd2;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_vec(i);
      chk($sformatf("wrap%0d_addr", i), c_addr, i % 4);
    end
    @(posedge clk); #1;
    for (int n = 0; n < 300; n++) begin
      send(5'd28 + 5'(n % 4), 5'd0, 5'd0, 5'd0, 5'd0, 26'd0);
      if (n == 254) chk("sat_at_255", c_cnt, 255);
    end
    chk("sat_final", c_cnt, 255);
    chk("sat_sticky", c_err, 1);
    chk("sat_no_valid", c_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
